// File: rtl/ntsc_composite_encoder_if.sv
// Pixel/timing enables and level-table write port from the PPU side, plus the DAC-facing outputs.
interface ntsc_composite_encoder_if #(
  parameter int unsigned DAC_WIDTH = 8
);
  logic                 frame_start;
  logic                 line_start;
  logic                 luminance_EN;
  logic                 chrominance_EN;
  logic                 sync_EN;
  logic                 colorBurst_EN;
  logic [2:0]           emphasis;
  logic [5:0]           pixelColour;
  logic                 lvl_we;
  logic [3:0]           lvl_addr;
  logic [DAC_WIDTH-1:0] lvl_data;
  logic [DAC_WIDTH-1:0] videoOut;
  logic                 videoOut_valid;
  logic [3:0]           phase;

  modport master (
    output frame_start, line_start, luminance_EN, chrominance_EN, sync_EN, colorBurst_EN,
           emphasis, pixelColour, lvl_we, lvl_addr, lvl_data,
    input  videoOut, videoOut_valid, phase
  );

  modport slave (
    input  frame_start, line_start, luminance_EN, chrominance_EN, sync_EN, colorBurst_EN,
           emphasis, pixelColour, lvl_we, lvl_addr, lvl_data,
    output videoOut, videoOut_valid, phase
  );
endinterface

// File: rtl/ntsc_composite_encoder.sv
// NES-style composite encoder: 12-phase subcarrier counter, two-stage pipeline and a
// runtime-writable 16-entry level table producing registered DAC codes.
module ntsc_composite_encoder #(
  parameter int unsigned DAC_WIDTH          = 8,
  parameter int unsigned LINE_PHASE_ADVANCE = 4,
  parameter logic [7:0]  SYNC_LEVEL         = 8'd0,
  parameter logic [7:0]  BURST_HIGH         = 8'd69,
  parameter logic [7:0]  BURST_LOW          = 8'd23
) (
  input  logic                   clock,
  input  logic                   reset,
  ntsc_composite_encoder_if.slave bus
);

  localparam int unsigned SHIFT      = DAC_WIDTH - 8;
  localparam int unsigned NUM_PHASES = 12;
  localparam int unsigned NUM_LEVELS = 16;
  localparam logic [3:0]  ADV        = 4'(LINE_PHASE_ADVANCE % NUM_PHASES);
  localparam logic [3:0]  BLACK_IDX  = 4'b1001;

  function automatic logic [DAC_WIDTH-1:0] scale8(input logic [7:0] v);
    return DAC_WIDTH'(v) << SHIFT;
  endfunction

  // Index is {low_sel, att, lum[1:0]}.
  function automatic logic [7:0] default_level(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd0:    v = 8'd94;
      4'd1:    v = 8'd128;
      4'd2:    v = 8'd168;
      4'd3:    v = 8'd168;
      4'd4:    v = 8'd76;
      4'd5:    v = 8'd103;
      4'd6:    v = 8'd136;
      4'd7:    v = 8'd136;
      4'd8:    v = 8'd34;
      4'd9:    v = 8'd47;
      4'd10:   v = 8'd84;
      4'd11:   v = 8'd134;
      4'd12:   v = 8'd29;
      4'd13:   v = 8'd39;
      4'd14:   v = 8'd68;
      default: v = 8'd110;
    endcase
    return v;
  endfunction

  // Square wave of the subcarrier shifted by hue h: high for six of the twelve phases.
  function automatic logic wave(input logic [3:0] ph, input logic [3:0] h);
    logic [4:0] s;
    s = 5'(ph) + 5'(h);
    if (s >= 5'd24)      s = s - 5'd24;
    else if (s >= 5'd12) s = s - 5'd12;
    return s < 5'd6;
  endfunction

  logic [3:0]           phase_q, phase_d;
  logic [3:0]           line_q, line_d;
  logic [4:0]           adv_sum;

  logic                 s1_sync_q, s1_burst_q, s1_luma_q, s1_chroma_q;
  logic [2:0]           s1_emph_q;
  logic [5:0]           s1_pix_q;
  logic [3:0]           s1_phase_q;
  logic                 s1_valid_q;

  logic [DAC_WIDTH-1:0] lvl_q [NUM_LEVELS];
  logic [DAC_WIDTH-1:0] video_q, video_d;
  logic                 valid_q;

  logic [3:0]           hue;
  logic [1:0]           lum;
  logic                 sel_hi;
  logic                 att;

  // Subcarrier phase: free-running mod 12, re-seeded per line, zeroed per frame.
  always_comb begin
    line_d  = line_q;
    phase_d = phase_q;
    adv_sum = 5'(line_q) + 5'(ADV);
    if (bus.frame_start) begin
      line_d  = 4'd0;
      phase_d = 4'd0;
    end else if (bus.line_start) begin
      line_d  = (adv_sum >= 5'(NUM_PHASES)) ? 4'(adv_sum - 5'(NUM_PHASES)) : 4'(adv_sum);
      phase_d = line_d;
    end else begin
      phase_d = (phase_q == 4'(NUM_PHASES - 1)) ? 4'd0 : phase_q + 4'd1;
    end
  end

  // Stage 2 level selection from the registered stage-1 sample.
  always_comb begin
    hue     = s1_pix_q[3:0];
    lum     = s1_pix_q[5:4];
    sel_hi  = (!s1_chroma_q || (hue == 4'h0) || wave(s1_phase_q, hue)) && (hue != 4'hD);
    att     = s1_chroma_q &&
              ((s1_emph_q[0] && wave(s1_phase_q, 4'hC)) ||
               (s1_emph_q[1] && wave(s1_phase_q, 4'h4)) ||
               (s1_emph_q[2] && wave(s1_phase_q, 4'h8)));
    video_d = lvl_q[{!sel_hi, att, lum}];
    if (s1_sync_q) begin
      video_d = scale8(SYNC_LEVEL);
    end else if (s1_burst_q) begin
      video_d = wave(s1_phase_q, 4'h8) ? scale8(BURST_HIGH) : scale8(BURST_LOW);
    end else if (!s1_luma_q || (hue >= 4'hE)) begin
      video_d = lvl_q[BLACK_IDX];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q     <= 4'd0;
      line_q      <= 4'd0;
      s1_sync_q   <= 1'b0;
      s1_burst_q  <= 1'b0;
      s1_luma_q   <= 1'b0;
      s1_chroma_q <= 1'b0;
      s1_emph_q   <= 3'd0;
      s1_pix_q    <= 6'd0;
      s1_phase_q  <= 4'd0;
      s1_valid_q  <= 1'b0;
      video_q     <= scale8(SYNC_LEVEL);
      valid_q     <= 1'b0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
        lvl_q[i] <= scale8(default_level(4'(i)));
      end
    end else begin
      phase_q     <= phase_d;
      line_q      <= line_d;
      s1_sync_q   <= bus.sync_EN;
      s1_burst_q  <= bus.colorBurst_EN;
      s1_luma_q   <= bus.luminance_EN;
      s1_chroma_q <= bus.chrominance_EN;
      s1_emph_q   <= bus.emphasis;
      s1_pix_q    <= bus.pixelColour;
      s1_phase_q  <= phase_q;
      s1_valid_q  <= 1'b1;
      video_q     <= video_d;
      valid_q     <= s1_valid_q;
      // Stage 2 reads the table before this edge's write lands.
      if (bus.lvl_we) begin
        lvl_q[bus.lvl_addr] <= bus.lvl_data;
      end
    end
  end

  assign bus.videoOut       = video_q;
  assign bus.videoOut_valid = valid_q;
  assign bus.phase          = phase_q;

endmodule
